// File: rtl/fmul_arb_if.sv
`timescale 1ns/1ps
// fmul_arb_if: requester, response and shared-multiplier signals of fmul_arb.
// FMUL_ARB_OVF_STICKY_EN adds ovf_clr/ovf_sticky.
interface fmul_arb_if;
    logic        req0_valid, req0_ready, req0_rnd;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_rnd;
    logic [31:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready;
    logic [31:0] rsp0_c;
    logic [1:0]  rsp0_ovf;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp1_c;
    logic [1:0]  rsp1_ovf;
    logic [31:0] mul_a, mul_b, mul_c;
    logic        mul_en, mul_round;
    logic [1:0]  mul_ovf;
    logic        busy;
`ifdef FMUL_ARB_OVF_STICKY_EN
    logic        ovf_clr;
    logic [3:0]  ovf_sticky;
`endif
    modport master (
        output req0_valid, req0_rnd, req0_a, req0_b, req1_valid, req1_rnd, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, mul_c, mul_ovf,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_c, rsp0_ovf, rsp1_valid, rsp1_c, rsp1_ovf,
        input  mul_a, mul_b, mul_en, mul_round, busy
`ifdef FMUL_ARB_OVF_STICKY_EN
        , output ovf_clr, input ovf_sticky
`endif
    );
    modport slave (
        input  req0_valid, req0_rnd, req0_a, req0_b, req1_valid, req1_rnd, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, mul_c, mul_ovf,
        output req0_ready, req1_ready, rsp0_valid, rsp0_c, rsp0_ovf, rsp1_valid, rsp1_c, rsp1_ovf,
        output mul_a, mul_b, mul_en, mul_round, busy
`ifdef FMUL_ARB_OVF_STICKY_EN
        , input ovf_clr, output ovf_sticky
`endif
    );
endinterface

// File: rtl/fmul_arb.sv
`timescale 1ns/1ps
// fmul_arb: two-requester round-robin front end for a shared 3-cycle FP multiplier.
// Optional FMUL_ARB_OVF_STICKY_EN adds per-requester sticky exponent flags.
module fmul_arb #(
    parameter int RSP_DEPTH = 4
) (
    input logic       clk,
    input logic       rst_n,
    fmul_arb_if.slave bus
);
    localparam int AW = $clog2(RSP_DEPTH);
    typedef logic [AW:0] cnt_t;
    logic [1:0]  req_v, rsp_rdy, elig, rdy, grant, push, pop, empty;
    cnt_t        cred_q [2];
    cnt_t        cred_d [2];
    cnt_t        wp_q [2];
    cnt_t        rp_q [2];
    logic [33:0] mem_q [2][RSP_DEPTH];
    logic [33:0] head [2];
    logic        ptr_q, ptr_d;
    logic [2:0]  tv_q, tid_q;
    logic [1:0]  trnd_q;
    assign req_v   = {bus.req1_valid, bus.req0_valid};
    assign rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            elig[n]  = cred_q[n] < cnt_t'(RSP_DEPTH);
            empty[n] = wp_q[n] == rp_q[n];
            push[n]  = tv_q[2] && tid_q[2] == 1'(n);
            head[n]  = empty[n] ? '0 : mem_q[n][rp_q[n][AW-1:0]];
        end
        // A lone eligible requester wins; the pointer only breaks a real tie.
        rdy[0] = rst_n & elig[0] & (~ptr_q | ~(req_v[1] & elig[1]));
        rdy[1] = rst_n & elig[1] & (ptr_q | ~(req_v[0] & elig[0]));
        grant  = req_v & rdy;
        pop    = ~empty & rsp_rdy;
        for (int n = 0; n < 2; n++)
            cred_d[n] = cred_q[n] + cnt_t'(grant[n]) - cnt_t'(pop[n]);
        ptr_d = grant[0] ? 1'b1 : grant[1] ? 1'b0 : ptr_q;
    end
    assign bus.req0_ready = rdy[0];
    assign bus.req1_ready = rdy[1];
    assign bus.rsp0_valid = ~empty[0];
    assign bus.rsp1_valid = ~empty[1];
    assign bus.rsp0_c     = head[0][33:2];
    assign bus.rsp0_ovf   = head[0][1:0];
    assign bus.rsp1_c     = head[1][33:2];
    assign bus.rsp1_ovf   = head[1][1:0];
    assign bus.mul_en     = |grant;
    assign bus.mul_a      = grant[0] ? bus.req0_a : grant[1] ? bus.req1_a : '0;
    assign bus.mul_b      = grant[0] ? bus.req0_b : grant[1] ? bus.req1_b : '0;
    assign bus.mul_round  = tv_q[1] & trnd_q[1];
    assign bus.busy       = |tv_q | ~&empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv_q   <= '0;
            tid_q  <= '0;
            trnd_q <= '0;
            ptr_q  <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                cred_q[n] <= '0;
                wp_q[n]   <= '0;
                rp_q[n]   <= '0;
            end
        end else begin
            tv_q   <= {tv_q[1:0], |grant};
            tid_q  <= {tid_q[1:0], grant[1]};
            trnd_q <= {trnd_q[0], grant[1] ? bus.req1_rnd : bus.req0_rnd};
            ptr_q  <= ptr_d;
            for (int n = 0; n < 2; n++) begin
                cred_q[n] <= cred_d[n];
                wp_q[n]   <= wp_q[n] + cnt_t'(push[n]);
                rp_q[n]   <= rp_q[n] + cnt_t'(pop[n]);
            end
        end
    end
    // Result storage carries no reset; empty pointers mask stale entries.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++)
            if (push[n]) mem_q[n][wp_q[n][AW-1:0]] <= {bus.mul_c, bus.mul_ovf};
    end
`ifdef FMUL_ARB_OVF_STICKY_EN
    logic [3:0] sticky_q, sticky_d;
    always_comb
        sticky_d = bus.ovf_clr ? '0 :
                   sticky_q | {push[1] ? bus.mul_ovf : 2'b00, push[0] ? bus.mul_ovf : 2'b00};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= '0;
        else        sticky_q <= sticky_d;
    end
    assign bus.ovf_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_fmul_arb.sv
`timescale 1ns/1ps
// tb_fmul_arb: directed checks of fmul_arb against a behavioural 3-cycle multiplier.
// Known IEEE products are tabulated; other operands yield (a^b) with LSB chopped when rnd=0.
module tb_fmul_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   g;
    logic seen;
    fmul_arb_if bus();
    fmul_arb #(.RSP_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    logic [2:0]  mv_q = '0;
    logic [31:0] ma_q [3];
    logic [31:0] mb_q [3];
    logic        mr_q;
    logic [33:0] mres;
    always @(posedge clk) begin
        mv_q    <= {mv_q[1:0], bus.mul_en};
        ma_q[0] <= bus.mul_a;
        mb_q[0] <= bus.mul_b;
        for (int i = 1; i < 3; i++) begin
            ma_q[i] <= ma_q[i-1];
            mb_q[i] <= mb_q[i-1];
        end
        mr_q <= bus.mul_round;
    end
    function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b, input logic r);
        if (a == 32'h3FC00000 && b == 32'h3FC00000) return {32'h40100000, 2'b00};
        if (a == 32'h3FC00000 && b == 32'hC0200000) return {32'hC0700000, 2'b00};
        if (a == 32'h7F000000 && b == 32'h7F000000) return {32'h7F800000, 2'b01};
        return {(a ^ b) & {31'h7FFFFFFF, r}, 2'b00};
    endfunction
    assign mres        = mv_q[2] ? fmul(ma_q[2], mb_q[2], mr_q) : {32'hDEADBEEF, 2'b11};
    assign bus.mul_c   = mres[33:2];
    assign bus.mul_ovf = mres[1:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic r);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_rnd = r;
    endtask
    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic r);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_rnd = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
`ifdef FMUL_ARB_OVF_STICKY_EN
        bus.ovf_clr = 1'b0;
`endif
        step();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_mul_en", bus.mul_en, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        chk("rst_mul_round", bus.mul_round, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 0);
        chk("rst_rsp0_c", bus.rsp0_c, 0);
        chk("rst_rsp1_ovf", bus.rsp1_ovf, 0);
`ifdef FMUL_ARB_OVF_STICKY_EN
        chk("rst_sticky", bus.ovf_sticky, 0);
`endif
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        rst_n = 1'b1;

        // single op, 4-cycle latency
        drive0(1, 32'h3FC00000, 32'h3FC00000, 1);
        #1;
        chk("A_ready0", bus.req0_ready, 1);
        chk("A_mul_en", bus.mul_en, 1);
        chk("A_mul_a", bus.mul_a, 32'h3FC00000);
        chk("A_mul_b", bus.mul_b, 32'h3FC00000);
        step();
        bus.req0_valid = 1'b0;
        #1;
        chk("A_idle_mul_en", bus.mul_en, 0);
        chk("A_idle_mul_a", bus.mul_a, 0);
        chk("A_busy", bus.busy, 1);
        step();
        chk("A_round_c2", bus.mul_round, 1);
        step();
        chk("A_valid_c3", bus.rsp0_valid, 0);
        step();
        chk("A_valid_c4", bus.rsp0_valid, 1);
        chk("A_c", bus.rsp0_c, 32'h40100000);
        chk("A_ovf", bus.rsp0_ovf, 0);
        bus.rsp0_ready = 1'b1;
        step();
        chk("A_popped", bus.rsp0_valid, 0);
        chk("A_idle_busy", bus.busy, 0);

        // rounding alignment, back-to-back rnd=1,0,1
        drive0(1, 32'h11, 0, 1);
        step();
        drive0(1, 32'h23, 0, 0);
        step();
        drive0(1, 32'h35, 0, 1);
        #1;
        chk("B_round_c2", bus.mul_round, 1);
        step();
        bus.req0_valid = 1'b0;
        #1;
        chk("B_round_c3", bus.mul_round, 0);
        step();
        chk("B_round_c4", bus.mul_round, 1);
        chk("B_c0", bus.rsp0_c, 32'h11);
        step();
        chk("B_c1", bus.rsp0_c, 32'h22);
        step();
        chk("B_c2", bus.rsp0_c, 32'h35);
        step();
        chk("B_empty", bus.rsp0_valid, 0);

        // contention from reset release
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.rsp1_ready = 1'b1;
        drive0(1, 32'h3FC00000, 32'h3FC00000, 1);
        drive1(1, 32'h3FC00000, 32'hC0200000, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("C_ready0_%0d", i), bus.req0_ready, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("C_ready1_%0d", i), bus.req1_ready, (i % 2 == 1) ? 1 : 0);
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("C_rsp0_valid", bus.rsp0_valid, 1);
        chk("C_rsp0_c", bus.rsp0_c, 32'h40100000);
        step();
        chk("C_rsp1_valid", bus.rsp1_valid, 1);
        chk("C_rsp1_c", bus.rsp1_c, 32'hC0700000);
        chk("C_rsp0_gap", bus.rsp0_valid, 0);
        step(4);
        chk("C_drained_busy", bus.busy, 0);

        // backpressure on requester 1
        bus.rsp1_ready = 1'b0;
        drive1(1, 32'h100, 0, 1);
        g = 0;
        for (int i = 0; i < 8; i++) begin
            bus.req1_a = 32'h100 + 32'(g);
            #1;
            if (bus.req1_ready) g++;
            step();
        end
        chk("D_grants", 32'(g), 4);
        chk("D_ready_off", bus.req1_ready, 0);
        chk("D_busy", bus.busy, 1);
        bus.rsp1_ready = 1'b1;
        bus.req1_a = 32'h200;
        #1;
        chk("D_c0", bus.rsp1_c, 32'h100);
        chk("D_ready_still_off", bus.req1_ready, 0);
        step();
        chk("D_c1", bus.rsp1_c, 32'h101);
        chk("D_ready_back", bus.req1_ready, 1);
        step();
        bus.req1_valid = 1'b0;
        #1;
        chk("D_c2", bus.rsp1_c, 32'h102);
        step();
        chk("D_c3", bus.rsp1_c, 32'h103);
        step();
        chk("D_gap", bus.rsp1_valid, 0);
        step();
        chk("D_new_valid", bus.rsp1_valid, 1);
        chk("D_new_c", bus.rsp1_c, 32'h200);
        step();

        // reset mid-flight
        drive0(1, 32'h3FC00000, 32'hC0200000, 1);
        step();
        bus.req0_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("E_busy_in_rst", bus.busy, 0);
        chk("E_round_in_rst", bus.mul_round, 0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen |= bus.rsp0_valid;
            step();
        end
        chk("E_no_rsp", seen, 0);
        chk("E_busy", bus.busy, 0);
        drive0(1, 32'h3FC00000, 32'hC0200000, 1);
        step();
        bus.req0_valid = 1'b0;
        step(3);
        chk("E_reissue_valid", bus.rsp0_valid, 1);
        chk("E_reissue_c", bus.rsp0_c, 32'hC0700000);
        step();

        // exponent overflow flag
        drive0(1, 32'h7F000000, 32'h7F000000, 1);
        step();
        bus.req0_valid = 1'b0;
        step(3);
        chk("F_c", bus.rsp0_c, 32'h7F800000);
        chk("F_ovf", bus.rsp0_ovf, 32'h1);
`ifdef FMUL_ARB_OVF_STICKY_EN
        chk("F_sticky_set", bus.ovf_sticky, 4'b0001);
        step();
        chk("F_sticky_hold", bus.ovf_sticky, 4'b0001);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        #1;
        chk("F_sticky_clr", bus.ovf_sticky, 0);
`else
        step();
`endif
        chk("F_empty", bus.rsp0_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fmul_arb.md
FMUL_ARB -- requirements
Module: fmul_arb

Interface
REQ-001 SHALL have parameter: RSP_DEPTH, 4, per-requester result buffer depth and credit limit (power of 2, 2..16).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports, for N in 0,1:
- reqN_valid  in  1  operation request.
- reqN_ready  out  1  grant; transfer when valid&ready.
- reqN_a  in  32  IEEE-754 single multiplicand.
- reqN_b  in  32  IEEE-754 single multiplier.
- reqN_rnd  in  1  rounding select, 1=nearest, 0=chop.
REQ-005 SHALL have ports, for N in 0,1:
- rspN_valid  out  1  result available.
- rspN_ready  in  1  result accepted.
- rspN_c  out  32  product.
- rspN_ovf  out  2  exponent flag, 01=over, 10=under, 00=none.
REQ-006 SHALL have shared multiplier ports:
- mul_a  out  32  operand a.
- mul_b  out  32  operand b.
- mul_en  out  1  input-register load enable.
- mul_round  out  1  rounding select.
- mul_c  in  32  result.
- mul_ovf  in  2  overflow flag.
REQ-007 SHALL have port: busy  out  1  any operation in flight or buffered.

Function
REQ-008 The multiplier SHALL have a fixed latency: operands are loaded at the end of issue cycle T, rounding is applied during cycle T+2, and the result is valid on mul_c/mul_ovf during cycle T+3.
REQ-009 Requester N SHALL be eligible when its credit count (in flight plus buffered) is less than RSP_DEPTH.
REQ-010 At most one grant SHALL be issued per cycle. reqN_ready is combinational from eligibility and the arbitration pointer, independent of reqN_valid.
REQ-011 Arbitration SHALL be round-robin.
- Pointer is reset to 0 and names the preferred requester.
- When both requesters are valid and eligible, the preferred one is granted, and the pointer moves to the other after the grant.
- A single valid, eligible requester is granted regardless of the pointer.
REQ-012 In the issue cycle, mul_en SHALL be 1 and mul_a/mul_b SHALL carry the granted operands. Otherwise mul_en=0 and mul_a=mul_b=0.
REQ-013 A 3-stage tag pipeline {valid, id, rnd} SHALL shift every cycle.
- mul_round = rnd of stage 2.
- When stage 2 is invalid, mul_round = 0.
REQ-014 When tag stage 3 is valid, {mul_c, mul_ovf} SHALL be written into requester id's result FIFO at the end of that cycle. mul_c/mul_ovf in cycles with an invalid stage-3 tag SHALL be ignored.
REQ-015 Issue-to-rspN_valid latency SHALL be 4 cycles minimum, and results SHALL return in issue order per requester.
REQ-016 rspN_valid SHALL equal the FIFO not-empty state; rspN_c/rspN_ovf SHALL show the FIFO head. The head is popped on rspN_valid&rspN_ready.
REQ-017 The credit counter SHALL increment on grant and decrement on response handshake; a simultaneous grant and handshake leaves it unchanged. The credit limit guarantees the FIFO never overflows.
REQ-018 A write into an empty FIFO SHALL be visible the next cycle. A simultaneous push and pop on a full FIFO SHALL be legal. FIFO pointers SHALL wrap modulo RSP_DEPTH.
REQ-019 busy SHALL be 1 whenever any tag stage is valid or any FIFO is non-empty.

Reset
REQ-020 On rst_n low, the block SHALL immediately clear:
- tag pipeline, credits, FIFO pointers and arbitration pointer.
- Outputs: reqN_ready=0 while in reset, rspN_valid=0, rspN_c=0, rspN_ovf=0, mul_en=0, mul_a=0, mul_b=0, mul_round=0, busy=0.
REQ-021 In-flight operations SHALL be discarded on reset mid-operation; no response SHALL be produced for them after reset release.

Configuration
REQ-022 With macro FMUL_ARB_OVF_STICKY_EN defined:
- Ports ovf_clr (in, 1) and ovf_sticky (out, 4) SHALL exist.
- ovf_sticky[2N+1:2N] SHALL OR-accumulate the mul_ovf values written to FIFO N.
- ovf_clr=1 clears the sticky bits, with clear taking priority over a same-cycle set.
- ovf_sticky resets to 0.
REQ-023 Without FMUL_ARB_OVF_STICKY_EN, these ports and registers SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-024 Single op: req0 a=0x3FC00000, b=0x3FC00000, rnd=1; issue cycle 0 -> rsp0_valid in cycle 4, rsp0_c=0x40100000, rsp0_ovf=00.
REQ-025 Contention: req0 and req1 valid continuously from reset release, rsp ready=1 -> grants alternate 0,1,0,1 starting with requester 0, one grant per cycle.
REQ-026 Rounding alignment: back-to-back ops with rnd=1,0,1 -> mul_round=1,0,1 in cycles 2,3,4.
REQ-027 Backpressure: rsp1_ready=0, req1 valid continuously, RSP_DEPTH=4 -> exactly 4 grants, then req1_ready=0. Releasing rsp1_ready drains results in order and re-enables grants.
REQ-028 Reset mid-flight: rst_n low for 1 cycle at cycle 2 after issuing a=0x3FC00000, b=0xC0200000 -> no rsp0_valid afterwards, busy=0. A re-issue after reset returns 0xC0700000.
REQ-029 Sticky (macro defined): op causing mul_ovf=01 -> ovf_sticky[1:0]=01 until an ovf_clr pulse, then 00.
